// File: rtl/mips_pkg.sv
// mips_pkg: shared loader state encoding and word-shape constants
package mips_pkg;
  localparam int WORD_W = 32;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [2:0] {HDR, LOAD, DRAIN, CHK, RUN, ERR} state_t;
endpackage

// File: rtl/mips_boot_loader_byte_to_word.sv
// byte_to_word: assembles big-endian words from accepted stream bytes
module byte_to_word
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [7:0]        data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);
  logic [1:0]        cnt;
  logic [WORD_W-9:0] sr;
  assign word_valid = en && cnt == 2'(BYTES_PER_WORD - 1);
  assign word = {sr, data};
  // Shift each accepted byte in below the earlier ones; reset drops a partial word
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sr  <= '0;
    end else if (en) begin
      cnt <= cnt + 2'd1;
      sr  <= {sr[WORD_W-17:0], data};
    end
  end
endmodule

// File: rtl/mips_boot_loader.sv
// mips_boot_loader: byte-serial imem loader holding the core in reset; MIPS_BOOT_CHECKSUM_EN adds an XOR check word
module mips_boot_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);
  localparam logic [WORD_W-1:0] cap = WORD_W'(1) << ADDR_W;
  state_t            state;
  logic [ADDR_W:0]   k;
  logic [ADDR_W:0]   n;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  assign in_ready = !rst && (state == HDR || state == LOAD || state == CHK);
  byte_to_word u_b2w (
    .clk(clk),
    .rst(rst),
    .en(in_valid && in_ready),
    .data(in_data),
    .word_valid(word_valid),
    .word(word)
  );
`ifdef MIPS_BOOT_CHECKSUM_EN
  logic [WORD_W-1:0] xsum;
  // Running XOR of payload words, cleared while waiting for the header
  always_ff @(posedge clk) begin
    if (rst || state == HDR) xsum <= '0;
    else if (state == LOAD && word_valid) xsum <= xsum ^ word;
  end
`endif
  // Load sequencer; core release is registered from the RUN state so it trails DRAIN by a cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HDR;
      k          <= '0;
      n          <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      cpu_rst <= state != RUN;
      done    <= state == RUN;
      case (state)
        HDR: if (word_valid) begin
          if (word == '0) state <= DRAIN;
          else if (word > cap) begin
            state <= ERR;
            error <= 1'b1;
          end else begin
            state <= LOAD;
            n     <= word[ADDR_W:0];
          end
        end
        LOAD: if (word_valid) begin
          imem_we    <= 1'b1;
          imem_addr  <= k[ADDR_W-1:0];
          imem_wdata <= word;
          k          <= k + (ADDR_W+1)'(1);
          if (k + (ADDR_W+1)'(1) == n) state <= DRAIN;
        end
`ifdef MIPS_BOOT_CHECKSUM_EN
        DRAIN: state <= CHK;
        CHK: if (word_valid) begin
          if (word == xsum) state <= RUN;
          else begin
            state <= ERR;
            error <= 1'b1;
          end
        end
`else
        DRAIN: state <= RUN;
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_boot_loader.sv
// tb_mips_boot_loader: randomized loads checked against a queue-based model of the expected image
module tb_mips_boot_loader;
  localparam int ADDR_W = 10;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;
  int errors = 0;
  int checks = 0;
  logic [ADDR_W-1:0] got_a[$];
  logic [31:0]       got_d[$];

  mips_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we) begin
    got_a.push_back(imem_addr);
    got_d.push_back(imem_wdata);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    rst = 1'b0;
    got_a.delete();
    got_d.delete();
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int glo, input int ghi, output bit ok);
    bit b;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], int'($urandom_range(ghi, glo)), b);
      ok &= b;
    end
  endtask

  task automatic run_load(input string tag, input logic [31:0] n, input logic [31:0] pre[$],
                          input int glo, input int ghi, input bit bad_chk);
    logic [31:0] words[$];
    logic [31:0] x = '0;
    logic [31:0] w;
    bit ok, all, over;
    int nw;
    over = n > (32'd1 << ADDR_W);
    nw = over ? 0 : int'(n);
    send_word(n, glo, ghi, all);
    if (over) begin
      check({tag, "_error"}, error, 1);
      check({tag, "_ready"}, in_ready, 0);
      repeat (3) @(negedge clk);
      check({tag, "_cpu_rst"}, cpu_rst, 1);
      check({tag, "_done"}, done, 0);
      check({tag, "_nwrites"}, got_a.size(), 0);
      check({tag, "_accept"}, all, 1);
      return;
    end
    for (int i = 0; i < nw; i++) begin
      w = i < pre.size() ? pre[i] : $urandom;
      words.push_back(w);
      x ^= w;
      send_word(w, glo, ghi, ok);
      all &= ok;
    end
    check({tag, "_last_we"}, imem_we, nw > 0);
    if (nw > 0) begin
      check({tag, "_last_addr"}, imem_addr, nw - 1);
      check({tag, "_last_data"}, imem_wdata, words[nw-1]);
    end
`ifdef MIPS_BOOT_CHECKSUM_EN
    send_word(bad_chk ? x ^ 32'd1 : x, glo, ghi, ok);
    all &= ok;
    if (bad_chk) begin
      check({tag, "_chk_error"}, error, 1);
      repeat (2) @(negedge clk);
      check({tag, "_chk_cpu_rst"}, cpu_rst, 1);
      check({tag, "_chk_done"}, done, 0);
    end else begin
      check({tag, "_done_t1"}, done, 0);
      @(negedge clk);
      check({tag, "_done"}, done, 1);
      check({tag, "_cpu_rst"}, cpu_rst, 0);
    end
`else
    check({tag, "_done_t1"}, done, 0);
    @(negedge clk);
    check({tag, "_done_t2"}, done, 0);
    check({tag, "_cpu_rst_t2"}, cpu_rst, 1);
    @(negedge clk);
    check({tag, "_done"}, done, bad_chk | 1'b1);
    check({tag, "_cpu_rst"}, cpu_rst, 0);
`endif
    check({tag, "_error_final"}, error, bad_chk);
    check({tag, "_accept"}, all, 1);
    check({tag, "_nwrites"}, got_a.size(), nw);
    for (int i = 0; i < nw && i < got_a.size(); i++) begin
      check({tag, "_addr"}, got_a[i], i);
      check({tag, "_data"}, got_d[i], words[i]);
    end
    send_byte(8'hA5, 0, ok);
    check({tag, "_extra_refused"}, ok, 0);
    check({tag, "_no_extra_write"}, got_a.size(), nw);
  endtask

  initial begin
    logic [31:0] none[$];
    logic [31:0] ex[$];
    logic [31:0] one[$];
    bit ok;
    ex = '{32'h20080005, 32'h21090007};
    one = '{32'hAC0A0000};
    do_reset();
    run_load("ex", 32'd2, ex, 0, 0, 1'b0);
    do_reset();
    run_load("ex_gap", 32'd2, ex, 3, 3, 1'b0);
    do_reset();
    run_load("zero", 32'd0, none, 0, 1, 1'b0);
    do_reset();
    run_load("over", 32'h401, none, 0, 0, 1'b0);
    do_reset();
    run_load("over_max", 32'hFFFFFFFF, none, 0, 2, 1'b0);
    do_reset();
    send_word(32'd2, 0, 0, ok);
    send_word(32'h11223344, 0, 1, ok);
    send_byte(8'h55, 0, ok);
    send_byte(8'h66, 0, ok);
    do_reset();
    run_load("midrst", 32'd1, one, 0, 0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      do_reset();
      run_load("rand", 32'($urandom_range(8, 1)), none, 0, 2, 1'b0);
    end
    do_reset();
    run_load("full", 32'd1024, none, 0, 0, 1'b0);
`ifdef MIPS_BOOT_CHECKSUM_EN
    do_reset();
    run_load("badchk", 32'd2, ex, 0, 1, 1'b1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
